// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline run controller: state encoding,
// HALT opcode decode and default run/drain budgets.
package pipe_ctrl_pkg;

  // Run controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  // Opcode field of an instruction held in IF/ID
  localparam int OPC_MSB = 20;
  localparam int OPC_LSB = 17;
  localparam logic [OPC_MSB-OPC_LSB:0] HALT_OP = 4'hF;

  // Default budgets
  localparam int DEF_MAX_CYCLES   = 100000;
  localparam int DEF_DRAIN_CYCLES = 3;

  // True when the opcode field encodes HALT
  function automatic logic is_halt_op(input logic [OPC_MSB-OPC_LSB:0] opcode);
    return (opcode == HALT_OP);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Clear has priority over counting; counting stops at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run controller for the 5-stage SIMD AES pipeline: seeds the PC, lets the
// core run until HALT reaches ID or the cycle budget expires, drains
// EX/MEM/WB with bubbles and reports done/error plus a cycle count.
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int INSTR_W      = 21,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic               abort,
  input  logic [INSTR_W-1:0] id_instruction,
  output logic               core_rst_n,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_load_addr,
  output logic               run_en,
  output logic               id_bubble,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   cycle_count
);

  // Drain counter loads DRAIN_CYCLES-1 and exits after reaching zero
  localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  // MAX_CYCLES must be representable in CNT_W bits for the timeout to fire
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MAX_CYCLES - 1);

  run_state_e           r_state;
  run_state_e           w_state_next;
  logic                 r_timeout;
  logic                 w_timeout_next;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [DRAIN_W-1:0]   w_drain_next;
  logic                 r_run_armed;
  logic [ADDR_W-1:0]    r_pc_load_addr;

  logic                 r_core_rst_n;
  logic                 r_pc_load;
  logic                 r_run_en;
  logic                 r_id_bubble;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  logic                 w_start_accept;
  logic                 w_halt_seen;
  logic                 w_timeout_hit;
  logic                 w_cnt_en;
  logic [CNT_W-1:0]     w_cycle_count;
  logic                 w_unused;

  // Only the opcode field is decoded; the rest of IF/ID is irrelevant here
  assign w_unused = ^id_instruction;

  // HALT is only trusted once IF/ID has been filled by a real fetch
  assign w_halt_seen   = (r_state == ST_RUN) && r_run_armed &&
                         is_halt_op(id_instruction[OPC_MSB:OPC_LSB]);
  assign w_timeout_hit = (r_state == ST_RUN) && (w_cycle_count >= TIMEOUT_CNT);

  // Next-state decode; abort overrides everything, HALT beats timeout
  always_comb begin
    w_state_next   = r_state;
    w_timeout_next = r_timeout;
    w_drain_next   = r_drain_cnt;
    w_start_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next   = ST_LOAD;
          w_timeout_next = 1'b0;
          w_start_accept = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_halt_seen) begin
          w_state_next   = ST_DRAIN;
          w_timeout_next = 1'b0;
          w_drain_next   = DRAIN_LOAD;
        end else if (w_timeout_hit) begin
          w_state_next   = ST_DRAIN;
          w_timeout_next = 1'b1;
          w_drain_next   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_next = ST_DONE;
        end else begin
          w_drain_next = r_drain_cnt - DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_next   = ST_LOAD;
          w_timeout_next = 1'b0;
          w_start_accept = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (abort) begin
      w_state_next   = ST_IDLE;
      w_timeout_next = 1'b0;
      w_start_accept = 1'b0;
    end
  end

  // State register with outputs registered from the next-state decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_timeout      <= 1'b0;
      r_drain_cnt    <= '0;
      r_run_armed    <= 1'b0;
      r_pc_load_addr <= '0;
      r_core_rst_n   <= 1'b0;
      r_pc_load      <= 1'b0;
      r_run_en       <= 1'b0;
      r_id_bubble    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_timeout   <= w_timeout_next;
      r_drain_cnt <= w_drain_next;
      r_run_armed <= (r_state == ST_RUN);
      if (w_start_accept) begin
        r_pc_load_addr <= start_pc;
      end
      r_core_rst_n <= (w_state_next != ST_IDLE);
      r_pc_load    <= (w_state_next == ST_LOAD);
      r_run_en     <= (w_state_next == ST_RUN);
      r_id_bubble  <= (w_state_next == ST_DRAIN);
      r_busy       <= (w_state_next == ST_LOAD) || (w_state_next == ST_RUN) ||
                      (w_state_next == ST_DRAIN);
      r_done       <= (w_state_next == ST_DONE);
      r_error      <= (w_state_next == ST_DONE) && w_timeout_next;
    end
  end

  // Count RUN and DRAIN cycles; a new start zeroes it, abort freezes it
  assign w_cnt_en = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !abort;

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_clr   (w_start_accept),
    .i_en    (w_cnt_en),
    .o_count (w_cycle_count)
  );

  assign core_rst_n   = r_core_rst_n;
  assign pc_load      = r_pc_load;
  assign pc_load_addr = r_pc_load_addr;
  assign run_en       = r_run_en;
  assign id_bubble    = r_id_bubble;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign cycle_count  = w_cycle_count;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Self-checking bench for pipe_run_ctrl: scenario runs compared against a
// run-length model (run length = min(first HALT cycle >= 2, budget)).
module tb_pipe_run_ctrl;

  localparam int TB_MAX   = 50;
  localparam int SAT_MAX  = 14;
  localparam int DRAIN_N  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] start_pc = '0;
  logic        abort = 1'b0;
  logic [20:0] id_instruction = '0;
  logic        core_rst_n, pc_load, run_en, id_bubble, busy, done, error;
  logic [11:0] pc_load_addr;
  logic [31:0] cycle_count;

  logic        s_start = 1'b0;
  logic [11:0] s_start_pc = '0;
  logic        s_abort = 1'b0;
  logic [20:0] s_instr = '0;
  logic        s_core_rst_n, s_pc_load, s_run_en, s_id_bubble, s_busy, s_done, s_error;
  logic [11:0] s_pc_load_addr;
  logic [3:0]  s_cycle_count;

  int n_vec = 0;
  int n_miss = 0;
  int run_id = 0;

  always #5 clk = ~clk;

  pipe_run_ctrl #(.MAX_CYCLES(TB_MAX)) u_dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .abort(abort),
    .id_instruction(id_instruction), .core_rst_n(core_rst_n), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .run_en(run_en), .id_bubble(id_bubble),
    .busy(busy), .done(done), .error(error), .cycle_count(cycle_count)
  );

  pipe_run_ctrl #(.CNT_W(4), .MAX_CYCLES(SAT_MAX)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .start_pc(s_start_pc), .abort(s_abort),
    .id_instruction(s_instr), .core_rst_n(s_core_rst_n), .pc_load(s_pc_load),
    .pc_load_addr(s_pc_load_addr), .run_en(s_run_en), .id_bubble(s_id_bubble),
    .busy(s_busy), .done(s_done), .error(s_error), .cycle_count(s_cycle_count)
  );

  function automatic logic [20:0] mk_instr(input bit halt);
    logic [3:0] op;
    op = halt ? 4'hF : 4'($urandom_range(0, 14));
    return {op, 17'($urandom)};
  endfunction

  // One run from IDLE or DONE; flags = {core_rst_n,pc_load,run_en,id_bubble,busy,done,error}
  task automatic do_run(input logic [11:0] pc, input int h, input bit halt_first,
                        input bit noise, input int abort_at);
    int          r_len;
    bit          exp_err;
    logic [6:0]  exp_flags;
    logic [6:0]  got_flags;
    logic [31:0] exp_cnt;
    run_id++;
    if (h != 0 && h <= TB_MAX) begin
      r_len = h; exp_err = 1'b0;
    end else begin
      r_len = TB_MAX; exp_err = 1'b1;
    end
    start = 1'b1; start_pc = pc; id_instruction = mk_instr(1'b0);
    for (int t = 0; t <= r_len + DRAIN_N + 2; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp_cnt = (t == 0) ? 32'd0 : ((t - 1 < r_len + DRAIN_N) ? 32'(t - 1) : 32'(r_len + DRAIN_N));
      if (t == 0)                       exp_flags = 7'b1100100;
      else if (t <= r_len)              exp_flags = 7'b1010100;
      else if (t <= r_len + DRAIN_N)    exp_flags = 7'b1001100;
      else                              exp_flags = {6'b100001, exp_err};
      got_flags = {core_rst_n, pc_load, run_en, id_bubble, busy, done, error};
      n_vec++;
      if (got_flags !== exp_flags) begin
        n_miss++;
        $display("FAIL run%0d t=%0d flags: got %b expected %b", run_id, t, got_flags, exp_flags);
      end
      n_vec++;
      if (cycle_count !== exp_cnt) begin
        n_miss++;
        $display("FAIL run%0d t=%0d cycle_count: got %0d expected %0d", run_id, t, cycle_count, exp_cnt);
      end
      if (t == 0 || t == r_len + DRAIN_N + 1) begin
        n_vec++;
        if (pc_load_addr !== pc) begin
          n_miss++;
          $display("FAIL run%0d t=%0d pc_load_addr: got %h expected %h", run_id, t, pc_load_addr, pc);
        end
      end
      if (t == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        got_flags = {core_rst_n, pc_load, run_en, id_bubble, busy, done, error};
        n_vec++;
        if (got_flags !== 7'b0) begin
          n_miss++;
          $display("FAIL run%0d abort flags: got %b expected 0000000", run_id, got_flags);
        end
        n_vec++;
        if (cycle_count !== exp_cnt) begin
          n_miss++;
          $display("FAIL run%0d abort cycle_count: got %0d expected %0d", run_id, cycle_count, exp_cnt);
        end
        $display("run%0d pc=%h aborted at t=%0d", run_id, pc, t);
        return;
      end
      if (t >= 1 && t <= r_len)
        id_instruction = mk_instr((t == h) || (t == 1 && halt_first));
      else
        id_instruction = 21'($urandom);
      if (noise && t >= 1 && t <= r_len + DRAIN_N) begin
        start = 1'($urandom_range(0, 1));
        start_pc = 12'($urandom);
      end
    end
    $display("run%0d pc=%h halt=%0d first=%0d noise=%0d -> count=%0d err=%0d",
             run_id, pc, h, halt_first, noise, r_len + DRAIN_N, exp_err);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_vec++;
    if ({core_rst_n, pc_load, run_en, id_bubble, busy, done, error, pc_load_addr, cycle_count} !== '0) begin
      n_miss++;
      $display("FAIL reset outputs: got %b/%h/%0d expected all zero",
               {core_rst_n, pc_load, run_en, id_bubble, busy, done, error}, pc_load_addr, cycle_count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({core_rst_n, busy, done, cycle_count} !== '0) begin
      n_miss++;
      $display("FAIL reset idle: got core_rst_n=%b busy=%b done=%b count=%0d expected 0",
               core_rst_n, busy, done, cycle_count);
    end
    $display("reset checked");
  endtask

  task automatic test_basic();         do_run(12'h010, 20, 1'b0, 1'b0, -1); endtask
  task automatic test_timeout();       do_run(12'h3A5, 0, 1'b0, 1'b0, -1); endtask
  task automatic test_halt_at_timeout(); do_run(12'h111, TB_MAX, 1'b0, 1'b0, -1); endtask
  task automatic test_halt_window();   do_run(12'h044, 7, 1'b1, 1'b0, -1); endtask
  task automatic test_start_ignored(); do_run(12'h0F0, 12, 1'b0, 1'b1, -1); endtask

  task automatic test_abort_restart();
    do_run(12'h055, 15, 1'b0, 1'b0, 15 + 2);
    do_run(12'h066, 9, 1'b0, 1'b0, -1);
  endtask

  task automatic test_rearm_from_done();
    do_run(12'h020, 5, 1'b0, 1'b0, -1);
  endtask

  task automatic test_async_reset();
    start = 1'b1; start_pc = 12'h0AB; id_instruction = mk_instr(1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      id_instruction = mk_instr(1'b0);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({core_rst_n, pc_load, run_en, id_bubble, busy, done, error, pc_load_addr, cycle_count} !== '0) begin
      n_miss++;
      $display("FAIL async_reset outputs: got %b/%h/%0d expected all zero",
               {core_rst_n, pc_load, run_en, id_bubble, busy, done, error}, pc_load_addr, cycle_count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({core_rst_n, run_en, busy} !== 3'b000) begin
      n_miss++;
      $display("FAIL async_reset idle: got %b expected 000", {core_rst_n, run_en, busy});
    end
    $display("async reset mid-run checked");
  endtask

  task automatic test_random();
    int h;
    for (int i = 0; i < 10; i++) begin
      h = int'($urandom_range(2, 60));
      if (h > 55) h = 0;
      do_run(12'($urandom), h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_saturation();
    int seen = 0;
    s_start = 1'b1; s_start_pc = 12'h7E1; s_instr = mk_instr(1'b0);
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      s_instr = mk_instr(1'b0);
      if (s_done && seen == 0) seen = i;
    end
    n_vec++;
    if (seen != SAT_MAX + DRAIN_N + 1) begin
      n_miss++;
      $display("FAIL sat done_cycle: got %0d expected %0d", seen, SAT_MAX + DRAIN_N + 1);
    end
    n_vec++;
    if ({s_done, s_error, s_cycle_count} !== {1'b1, 1'b1, 4'hF}) begin
      n_miss++;
      $display("FAIL sat result: got done=%b err=%b count=%0d expected 1 1 15",
               s_done, s_error, s_cycle_count);
    end
    $display("saturation run done_cycle=%0d count=%0d", seen, s_cycle_count);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_halt_at_timeout();
    test_halt_window();
    test_abort_restart();
    test_start_ignored();
    test_rearm_from_done();
    test_async_reset();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
